// File: rtl/stoch_l2_norm_sched.sv
// Round-robin scheduler sharing one stochastic L2-norm unit among NUM_REQ requesters.
// Each job clears the unit, lets it warm up, then counts norm_y ones over a fixed window.
module stoch_l2_norm_sched #(
  parameter int NUM_REQ        = 4,
  parameter int VEC_LEN        = 2,
  parameter int WARMUP_CYCLES  = 64,
  parameter int MEASURE_CYCLES = 256,
  parameter int CNT_W          = $clog2(MEASURE_CYCLES + 1)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*VEC_LEN-1:0] up_all,
  input  logic [NUM_REQ*VEC_LEN-1:0] un_all,
  output logic [NUM_REQ-1:0]         grant,
  output logic [VEC_LEN-1:0]         norm_up,
  output logic [VEC_LEN-1:0]         norm_un,
  output logic                       norm_rst,
  input  logic                       norm_y,
  output logic [NUM_REQ-1:0]         done,
  output logic [CNT_W-1:0]           result,
  output logic                       busy
);

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CYC_MAX = (WARMUP_CYCLES > MEASURE_CYCLES) ? WARMUP_CYCLES : MEASURE_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    WARMUP  = 3'd2,
    MEASURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t             state, next_state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   owner_next;
  logic [PTR_W-1:0]   sel;
  logic [NUM_REQ-1:0] ge_mask;
  logic [NUM_REQ-1:0] hi_req;
  logic [NUM_REQ-1:0] pick;
  logic [CYC_W-1:0]   cyc_cnt;
  logic [CNT_W-1:0]   ones_cnt;
  logic               norm_rst_q;
  logic               owner_req;
  logic               warm_last;
  logic               meas_last;

  // Round-robin pick: lowest set request at or above rr_ptr, else lowest overall.
  always_comb begin
    ge_mask = '0;
    sel     = '0;
    for (int j = 0; j < NUM_REQ; j++) ge_mask[j] = (PTR_W'(j) >= rr_ptr);
    hi_req = req & ge_mask;
    for (int j = NUM_REQ - 1; j >= 0; j--) if (req[j]) sel = PTR_W'(j);
    for (int j = NUM_REQ - 1; j >= 0; j--) if (hi_req[j]) sel = PTR_W'(j);
    pick = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
  end

  assign owner_req  = |(req & grant);
  assign owner_next = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
  assign warm_last  = (cyc_cnt == CYC_W'(WARMUP_CYCLES - 1));
  assign meas_last  = (cyc_cnt == CYC_W'(MEASURE_CYCLES - 1));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|req) next_state = CLEAR;
      CLEAR:   next_state = owner_req ? WARMUP : IDLE;
      WARMUP:  if (!owner_req) next_state = IDLE;
               else if (warm_last) next_state = MEASURE;
      MEASURE: if (!owner_req) next_state = IDLE;
               else if (meas_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Leaving any busy state for IDLE (completion or abort) releases the unit and advances rr_ptr.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      grant      <= '0;
      cyc_cnt    <= '0;
      ones_cnt   <= '0;
      result     <= '0;
      norm_rst_q <= 1'b1;
    end else begin
      state      <= next_state;
      norm_rst_q <= (next_state == CLEAR);
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= pick;
            owner <= sel;
          end
        end
        CLEAR: cyc_cnt <= '0;
        WARMUP: begin
          cyc_cnt <= warm_last ? '0 : cyc_cnt + CYC_W'(1);
          if (warm_last) ones_cnt <= '0;
        end
        MEASURE: begin
          cyc_cnt  <= cyc_cnt + CYC_W'(1);
          ones_cnt <= ones_cnt + CNT_W'(norm_y);
        end
        DONE: result <= ones_cnt;
        default: ;
      endcase
      if (state != IDLE && next_state == IDLE) begin
        grant  <= '0;
        rr_ptr <= owner_next;
      end
    end
  end

  // Grant is only nonzero outside IDLE, so it alone selects the steered slice.
  always_comb begin
    norm_up = '0;
    norm_un = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        norm_up = norm_up | up_all[i*VEC_LEN +: VEC_LEN];
        norm_un = norm_un | un_all[i*VEC_LEN +: VEC_LEN];
      end
    end
  end

  assign done     = (state == DONE) ? grant : '0;
  assign busy     = (state != IDLE);
  assign norm_rst = norm_rst_q;

endmodule

// File: tb/tb_stoch_l2_norm_sched.sv
// Directed bench for stoch_l2_norm_sched; a small behavioural source stands in for the norm unit.
// Expected grants and counts are worked out by hand from the job schedule below.
module tb_stoch_l2_norm_sched;

  localparam int NUM_REQ = 4;
  localparam int VEC_LEN = 2;
  localparam int WARM    = 4;
  localparam int MEAS    = 16;
  localparam int CNT_W   = $clog2(MEAS + 1);
  localparam int JOB_CYC = 1 + WARM + MEAS + 1;

  logic                       CLK = 1'b0;
  logic                       RST;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*VEC_LEN-1:0] up_all;
  logic [NUM_REQ*VEC_LEN-1:0] un_all;
  logic [NUM_REQ-1:0]         grant;
  logic [VEC_LEN-1:0]         norm_up;
  logic [VEC_LEN-1:0]         norm_un;
  logic                       norm_rst;
  logic                       norm_y;
  logic [NUM_REQ-1:0]         done;
  logic [CNT_W-1:0]           result;
  logic                       busy;

  int tests_run = 0;
  int tests_failed = 0;
  int ymode = 0;
  int gcyc = 0;
  logic tog = 1'b0;

  logic [VEC_LEN-1:0] exp_up [NUM_REQ] = '{2'b01, 2'b10, 2'b11, 2'b00};
  logic [VEC_LEN-1:0] exp_un [NUM_REQ] = '{2'b10, 2'b01, 2'b00, 2'b11};

  stoch_l2_norm_sched #(
    .NUM_REQ(NUM_REQ), .VEC_LEN(VEC_LEN), .WARMUP_CYCLES(WARM),
    .MEASURE_CYCLES(MEAS), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .req(req), .up_all(up_all), .un_all(un_all),
    .grant(grant), .norm_up(norm_up), .norm_un(norm_un), .norm_rst(norm_rst),
    .norm_y(norm_y), .done(done), .result(result), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // gcyc is 0 in the grant (CLEAR) cycle, 1..4 in WARMUP, 5..20 in MEASURE.
  always @(posedge CLK) begin
    tog  <= ~tog;
    gcyc <= (grant == '0) ? 0 : gcyc + 1;
  end

  always_comb begin
    case (ymode)
      0:       norm_y = 1'b1;
      1:       norm_y = tog;
      2:       norm_y = norm_up[0] & ~norm_un[0];
      3:       norm_y = (gcyc < 5);
      default: norm_y = (gcyc < 8);
    endcase
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input int mode);
    req   = r;
    ymode = mode;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic waitGrant();
    int n = 0;
    while (grant == '0 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("grant_wait", 32'(grant != '0), 32'd1);
  endtask

  // Runs one full job for the expected owner, then drops that owner's request after done.
  task automatic runJob(input int owner, input int exp_res);
    int n;
    int rst_cnt;
    int steer_bad;
    logic [NUM_REQ-1:0] oh;
    oh = NUM_REQ'(1) << owner;
    waitGrant();
    checkOutput("grant_owner", 32'(grant), 32'(oh));
    checkOutput("clear_rst", 32'(norm_rst), 32'd1);
    checkOutput("steer_up", 32'(norm_up), 32'(exp_up[owner]));
    checkOutput("steer_un", 32'(norm_un), 32'(exp_un[owner]));
    n = 1;
    rst_cnt = 1;
    steer_bad = 0;
    while (done == '0 && n < 60) begin
      tick();
      n++;
      if (norm_rst) rst_cnt++;
      if (norm_up !== exp_up[owner] || norm_un !== exp_un[owner]) steer_bad++;
    end
    checkOutput("done_owner", 32'(done), 32'(oh));
    checkOutput("job_cycles", 32'(n), 32'(JOB_CYC));
    checkOutput("rst_cycles", 32'(rst_cnt), 32'd1);
    checkOutput("steer_hold", 32'(steer_bad), 32'd0);
    req[owner] = 1'b0;
    tick();
    checkOutput("result", 32'(result), 32'(exp_res));
    checkOutput("idle_grant", 32'(grant), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("idle_up", 32'(norm_up), 32'd0);
    checkOutput("idle_un", 32'(norm_un), 32'd0);
  endtask

  initial begin
    int dn;
    up_all = {exp_up[3], exp_up[2], exp_up[1], exp_up[0]};
    un_all = {exp_un[3], exp_un[2], exp_un[1], exp_un[0]};
    RST = 1'b1;
    applyStimulus(4'b1111, 2);
    repeat (3) tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_norm_rst", 32'(norm_rst), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_up", 32'(norm_up), 32'd0);
    RST = 1'b0;
    tick();
    checkOutput("first_grant", 32'(grant), 32'h1);

    // Round robin with all requesting; slice-dependent source gives 16/0/16/0.
    runJob(0, 16);
    runJob(1, 0);
    runJob(2, 16);
    runJob(3, 0);

    // rr_ptr wrapped to 0, so 0 wins over 3; then 3 follows.
    applyStimulus(4'b1001, 1);
    runJob(0, 8);
    applyStimulus(req, 4);
    runJob(3, 3);

    // Ones during CLEAR/WARMUP only must not be counted.
    applyStimulus(4'b0010, 3);
    runJob(1, 0);

    applyStimulus(4'b0100, 0);
    runJob(2, 16);

    // Abort owner 1 in its third MEASURE cycle; pending requester 2 goes next.
    applyStimulus(4'b0010, 0);
    waitGrant();
    checkOutput("abort_owner", 32'(grant), 32'h2);
    req[2] = 1'b1;
    dn = 0;
    repeat (7) begin
      tick();
      if (done != '0) dn++;
    end
    req[1] = 1'b0;
    tick();
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_grant", 32'(grant), 32'd0);
    checkOutput("abort_done", 32'(done | NUM_REQ'(dn)), 32'd0);
    checkOutput("abort_result", 32'(result), 32'd16);
    tick();
    checkOutput("after_abort_grant", 32'(grant), 32'h4);
    checkOutput("after_abort_rst", 32'(norm_rst), 32'd1);

    // Reset in the middle of owner 2's MEASURE window.
    repeat (10) tick();
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    RST = 1'b1;
    tick();
    checkOutput("midrst_grant", 32'(grant), 32'd0);
    checkOutput("midrst_norm_rst", 32'(norm_rst), 32'd1);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_result", 32'(result), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    RST = 1'b0;
    applyStimulus(4'b0000, 0);
    tick();
    checkOutput("post_rst_norm_rst", 32'(norm_rst), 32'd0);
    checkOutput("post_rst_grant", 32'(grant), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
